// File: rtl/vliw_bundle_loader.sv
// vliw_bundle_loader: packs streamed instruction words into bundles, writes them to imem, then runs the core
module vliw_bundle_loader #(
  parameter int SLOTS  = 10,
  parameter int SLOT_W = 32,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [CNT_W-1:0]        run_cycles,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [SLOT_W-1:0]       s_data,
  input  logic                    s_last,
  output logic                    imem_we,
  output logic [ADDR_W-1:0]       imem_addr,
  output logic [SLOTS*SLOT_W-1:0] imem_wdata,
  output logic                    proc_run,
  output logic                    busy,
  output logic                    done,
  output logic                    padded,
  output logic [ADDR_W-1:0]       bundle_count
);
  localparam int IW = $clog2(SLOTS);
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, RUN, DONE} state_t;
  state_t                        r_state;
  state_t                        w_next;
  logic [ADDR_W-1:0]             r_base;
  logic [CNT_W-1:0]              r_cnt;
  logic [IW-1:0]                 r_slot;
  logic [SLOTS-1:0][SLOT_W-1:0]  r_bundle;
  logic                          r_last;
  assign imem_addr  = r_base + bundle_count;
  assign imem_wdata = r_bundle;
  // next-state decode; s_ready only depends on the registered state so s_valid never reaches it combinationally
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? LOAD : IDLE;
      LOAD:    w_next = (s_valid && (s_last || r_slot == '0)) ? WRITE : LOAD;
      WRITE:   w_next = !r_last ? LOAD : (r_cnt != '0 ? RUN : DONE);
      RUN:     w_next = r_cnt == CNT_W'(1) ? DONE : RUN;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // sequence state, registered status outputs, bundle packing and run down-counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_base       <= '0;
      r_cnt        <= '0;
      r_slot       <= '0;
      r_bundle     <= '0;
      r_last       <= 1'b0;
      bundle_count <= '0;
      padded       <= 1'b0;
      s_ready      <= 1'b0;
      imem_we      <= 1'b0;
      proc_run     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      r_state  <= w_next;
      s_ready  <= w_next == LOAD;
      imem_we  <= w_next == WRITE;
      proc_run <= w_next == RUN;
      busy     <= w_next != IDLE;
      done     <= w_next == DONE;
      case (r_state)
        IDLE: if (start) begin
          r_base       <= base_addr;
          r_cnt        <= run_cycles;
          r_slot       <= IW'(SLOTS - 1);
          r_bundle     <= '0;
          r_last       <= 1'b0;
          bundle_count <= '0;
          padded       <= 1'b0;
        end
        LOAD: if (s_valid) begin
          r_bundle[r_slot] <= s_data;
          r_slot           <= r_slot - IW'(1);
          r_last           <= s_last;
          if (s_last && r_slot != '0) padded <= 1'b1;
        end
        WRITE: begin
          bundle_count <= bundle_count + ADDR_W'(1);
          r_bundle     <= '0;
          r_slot       <= IW'(SLOTS - 1);
        end
        RUN:     r_cnt <= r_cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_vliw_bundle_loader.sv
// tb_vliw_bundle_loader: randomized bench checked against a bundle-level reference model
`timescale 1ns/1ps
module tb_vliw_bundle_loader;
  localparam int SLOTS = 10;
  localparam int SW    = 32;
  localparam int BW    = SLOTS * SW;
  logic          clk = 1'b0, rst_n = 1'b1, start = 1'b0, s_valid = 1'b0, s_last = 1'b0;
  logic [31:0]   base_addr = '0, run_cycles = '0, s_data = '0;
  logic          s_ready, imem_we, proc_run, busy, done, padded;
  logic [31:0]   imem_addr, bundle_count;
  logic [BW-1:0] imem_wdata;
  int            nvec = 0, nerr = 0;
  logic [31:0]   prog [64];
  logic [31:0]   exp_addr[$], cap_addr[$];
  logic [BW-1:0] exp_data[$], cap_data[$];
  int            exp_rc = 0, exp_bc = 0, k = 0, run_cnt = 0;
  bit            exp_pad = 1'b0, active = 1'b0, seen_done = 1'b0;

  always #5 clk = ~clk;

  vliw_bundle_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .run_cycles(run_cycles),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .proc_run(proc_run), .busy(busy), .done(done), .padded(padded), .bundle_count(bundle_count)
  );

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] want);
    nvec++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  // Reference: the program split into SLOTS-word groups, first word in the top slot, tail zero-filled
  task automatic model(input logic [31:0] b, input int rc, input int n);
    logic [BW-1:0] d;
    exp_addr.delete(); exp_data.delete(); cap_addr.delete(); cap_data.delete();
    for (int bi = 0; bi * SLOTS < n; bi++) begin
      d = '0;
      for (int j = 0; j < SLOTS; j++)
        if (bi * SLOTS + j < n) d[(SLOTS-1-j)*SW +: SW] = prog[bi*SLOTS+j];
      exp_addr.push_back(b + 32'(bi));
      exp_data.push_back(d);
    end
    exp_rc = rc; exp_bc = exp_addr.size(); exp_pad = (n % SLOTS) != 0;
    run_cnt = 0; seen_done = 1'b0; active = 1'b0;
  endtask

  always @(negedge clk) if (rst_n) begin
    if (proc_run) run_cnt++;
    chk("we_ready_excl", imem_we && s_ready, 0);
    if (active) begin
      k++;
      chk("run_window", proc_run, k <= exp_rc);
      chk("done_pulse", done, k == exp_rc + 1);
      chk("write_after_last", imem_we, 0);
      if (k == exp_rc + 1) begin
        chk("bundle_count", bundle_count, exp_bc);
        chk("padded", padded, exp_pad);
        active = 1'b0; seen_done = 1'b1;
      end
    end else begin
      chk("run_idle", proc_run, 0);
      chk("done_idle", done, 0);
      if (imem_we) begin
        cap_addr.push_back(imem_addr); cap_data.push_back(imem_wdata);
        if (exp_addr.size() == 0) chk("unexpected_write", imem_we, 0);
        else begin
          chk("waddr", imem_addr, exp_addr.pop_front());
          chk("wdata", imem_wdata, exp_data.pop_front());
          if (exp_addr.size() == 0) begin active = 1'b1; k = 0; end
        end
      end
    end
  end

  task automatic run_prog(input logic [31:0] b, input int rc, input int n, input int gap, input bit poke);
    int i = 0, t = 0;
    bit hs;
    model(b, rc, n);
    base_addr = b; run_cycles = 32'(rc); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; base_addr = $urandom; run_cycles = $urandom;
    chk("ready_after_start", s_ready, 1);
    chk("busy_after_start", busy, 1);
    while (i < n && t < 2000) begin
      s_valid = $urandom_range(99) >= gap;
      s_data  = s_valid ? prog[i] : $urandom;
      s_last  = s_valid ? (i == n - 1) : 1'($urandom_range(1));
      start   = poke && i == 3;
      hs = s_valid && s_ready;
      @(posedge clk); #1;
      if (hs) i++;
      t++;
    end
    s_valid = 1'b0; s_last = 1'b0; start = 1'b0;
    chk("words_fed", i, n);
    for (t = 0; t < 1000 && !seen_done; t++) @(posedge clk);
    chk("done_seen", seen_done, 1);
    #1;
    chk("idle_after_done", busy, 0);
    chk("bc_hold", bundle_count, exp_bc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0]   sa[$];
    logic [BW-1:0] sd[$];
    #1 rst_n = 1'b0;
    #20;
    chk("rst_ready", s_ready, 0);   chk("rst_we", imem_we, 0);     chk("rst_run", proc_run, 0);
    chk("rst_busy", busy, 0);       chk("rst_done", done, 0);      chk("rst_pad", padded, 0);
    chk("rst_addr", imem_addr, 0);  chk("rst_wdata", imem_wdata, 0); chk("rst_bc", bundle_count, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) prog[i] = 32'(i + 1);
    run_prog(32'd4, 5, 10, 0, 1'b0);
    chk("t1_addr", cap_addr[0], 32'd4);
    chk("t1_data", cap_data[0], {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10});
    chk("t1_run", run_cnt, 5);
    chk("t1_bc", bundle_count, 1);
    chk("t1_pad", padded, 0);

    for (int i = 0; i < 23; i++) prog[i] = 32'(i + 1);
    run_prog(32'd0, 3, 23, 0, 1'b0);
    chk("t2_writes", cap_addr.size(), 3);
    chk("t2_addr2", cap_addr[2], 32'd2);
    chk("t2_data2", cap_data[2], {32'd21, 32'd22, 32'd23, 224'd0});
    chk("t2_pad", padded, 1);
    chk("t2_bc", bundle_count, 3);

    for (int i = 0; i < 20; i++) prog[i] = $urandom;
    begin
      logic [31:0] b;
      int rc;
      b = $urandom; rc = $urandom_range(1, 8);
      run_prog(b, rc, 20, 0, 1'b0);
      sa = cap_addr; sd = cap_data;
      run_prog(b, rc, 20, 50, 1'b0);
    end
    chk("gap_writes", cap_addr.size(), sa.size());
    for (int i = 0; i < sa.size() && i < cap_addr.size(); i++) begin
      chk("gap_addr", cap_addr[i], sa[i]);
      chk("gap_data", cap_data[i], sd[i]);
    end

    for (int i = 0; i < 20; i++) prog[i] = $urandom;
    run_prog(32'hFFFF_FFFF, 2, 20, 30, 1'b0);
    chk("wrap_addr0", cap_addr[0], 32'hFFFF_FFFF);
    chk("wrap_addr1", cap_addr[1], 32'h0);

    for (int i = 0; i < 12; i++) prog[i] = $urandom;
    run_prog($urandom, 0, 12, 20, 1'b1);
    chk("rc0_run", run_cnt, 0);

    for (int i = 0; i < 15; i++) prog[i] = $urandom;
    model(32'h0, 0, 0);
    base_addr = 32'h55; run_cycles = 32'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int j = 0; j < 6; j++) begin
      s_valid = 1'b1; s_data = prog[j]; s_last = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b0; rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", s_ready, 0);  chk("mid_rst_we", imem_we, 0);     chk("mid_rst_run", proc_run, 0);
    chk("mid_rst_busy", busy, 0);      chk("mid_rst_done", done, 0);      chk("mid_rst_pad", padded, 0);
    chk("mid_rst_addr", imem_addr, 0); chk("mid_rst_wdata", imem_wdata, 0); chk("mid_rst_bc", bundle_count, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_prog(32'h100, 4, 15, 40, 1'b0);

    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 35);
      for (int i = 0; i < n; i++) prog[i] = $urandom;
      run_prog($urandom, $urandom_range(0, 10), n, $urandom_range(0, 70), 1'($urandom_range(1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/vliw_bundle_loader.md
# vliw_bundle_loader

Hardware program loader and run controller for the VLIW core. Accepts a stream of SLOT_W-bit instruction words over a valid/ready handshake, packs them into SLOTS-wide bundles, writes each bundle into instruction memory at consecutive addresses from a base, then releases the processor for a programmed number of cycles and signals completion. Replaces hierarchical task-based instruction preloading with a synthesizable, parametrised path.

## Interface
- SLOTS, 10, instruction slots per bundle (≥2)
- SLOT_W, 32, bits per slot
- ADDR_W, 32, instruction-memory address width
- CNT_W, 32, run-cycle counter width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a load/run sequence (sampled in IDLE only)
- base_addr  in  ADDR_W  first bundle address, captured on start
- run_cycles  in  CNT_W  processor run length, captured on start
- s_valid  in  1  stream word valid
- s_ready  out  1  loader can accept a word
- s_data  in  SLOT_W  stream word
- s_last  in  1  final word of program (qualified by s_valid&&s_ready)
- imem_we  out  1  one-cycle bundle write strobe
- imem_addr  out  ADDR_W  bundle write address
- imem_wdata  out  SLOTS*SLOT_W  assembled bundle
- proc_run  out  1  processor clock-enable/run
- busy  out  1  not in IDLE
- done  out  1  one-cycle completion pulse
- padded  out  1  sticky: last bundle was zero-filled
- bundle_count  out  ADDR_W  bundles written this sequence

## Operation
- States: IDLE, LOAD, WRITE, RUN, DONE.
- IDLE: s_ready=0. start=1 → capture base_addr, run_cycles; clear slot index, bundle_count, padded, bundle register; → LOAD.
- LOAD: s_ready=1. Word accepted on s_valid&&s_ready; first word of a bundle fills slot SLOTS-1 (MSBs, bits [SLOTS*SLOT_W-1 -: SLOT_W]), successive words fill descending slots down to slot 0 (LSBs).
- Accepting the word for slot 0, or any word with s_last=1 → WRITE. If s_last arrives before slot 0, all unfilled slots are zero (zero word is NOP) and padded←1.
- WRITE: s_ready=0, imem_we=1, imem_addr=base+bundle_count (mod 2^ADDR_W), imem_wdata=bundle. Next cycle: bundle_count+1, bundle register cleared, slot index reset; → LOAD if last not yet seen, else → RUN (run_cycles≠0) or DONE (run_cycles=0).
- RUN: proc_run=1 for exactly run_cycles consecutive cycles (down-counter), then → DONE.
- DONE: done=1 for one cycle, → IDLE. bundle_count and padded hold until next start.
- start outside IDLE ignored. s_data/s_last ignored when s_ready=0.
- Address arithmetic wraps modulo 2^ADDR_W; no error.

## Timing
- Reset (async assert, sync-to-clk deassert usage): state=IDLE; s_ready, imem_we, proc_run, busy, done, padded=0; imem_addr, imem_wdata, bundle_count=0. Reset mid-operation discards partial bundle; no write issued.
- All outputs registered or decoded from state; no combinational path s_valid→s_ready.
- start at edge N → busy and s_ready high from cycle N+1.
- Full bundle with no stalls: SLOTS accept cycles + 1 WRITE cycle; throughput SLOTS/(SLOTS+1) words/cycle.
- imem_we high exactly one cycle per bundle, addresses strictly incrementing.
- proc_run rises the cycle after final WRITE, stays high run_cycles cycles; done follows in the next cycle.
- s_valid low in LOAD stalls indefinitely with no state change.

## Test plan
- SLOTS=10: start, base_addr=4, 10 words 0x01..0x0A, last on 0x0A, run_cycles=5 → one write at addr 4, wdata MSB slot 0x01 … LSB slot 0x0A, padded=0, proc_run 5 cycles, done pulse, bundle_count=1.
- 23 words, last on 23rd, base 0 → writes at 0,1,2; bundle 2 holds words 21–23 in slots 9–7, slots 6–0 zero; padded=1; bundle_count=3.
- Random s_valid gaps (≈50%) on 20-word program → identical imem writes to gap-free run; no word lost or duplicated.
- base_addr=0xFFFFFFFF, 20 words → writes at 0xFFFFFFFF then 0x00000000.
- run_cycles=0 → done one cycle after final WRITE, proc_run never asserted; start pulsed during LOAD ignored.
- rst_n low mid-bundle (after 6 words) → immediate IDLE, all outputs zero, no imem_we; fresh start then loads correctly.
